// File: rtl/beam_s2mm_framer_if.sv
// beam_s2mm_framer_if
//   One AXI4-Stream lane as used by the beam framer.
//   tdata  : DATA_W bits of payload (8 x 16-bit samples at DATA_W = 128)
//   tkeep  : byte enables, DATA_W/8 bits
//   tlast  : end-of-frame marker
//   tvalid : source has a beat
//   tready : sink accepts the beat
//   master : drives tdata/tkeep/tlast/tvalid, samples tready
//   slave  : samples tdata/tkeep/tlast/tvalid, drives tready
interface beam_s2mm_framer_if #(
  parameter int unsigned DATA_W = 128
);
  logic [DATA_W-1:0]   tdata;
  logic [DATA_W/8-1:0] tkeep;
  logic                tlast;
  logic                tvalid;
  logic                tready;

  modport master (output tdata, tkeep, tlast, tvalid, input tready);
  modport slave  (input tdata, tkeep, tlast, tvalid, output tready);
endinterface

// File: rtl/beam_s2mm_framer.sv
// beam_s2mm_framer
//   Frames the combined beam (real and imaginary AXI4-Stream lanes) into
//   fixed FRAME_BEATS-beat frames for two S2MM DMA channels. The input lanes
//   are accepted jointly so they never slip; each lane is buffered in its own
//   FIFO so the two DMA channels can drain independently. A start/stop FSM
//   gates capture so that only whole frames are ever emitted.
//
//   clock, reset        : single rising-edge clock, synchronous active-high reset
//   start, stop         : single-cycle control pulses
//   busy                : capture active or data still buffered
//   frame_count         : complete frames accepted since reset (wraps)
//   s_axis_real/imag    : beam input lanes (slave; tkeep/tlast ignored)
//   m_axis_real/imag_s2mm : framed output lanes to the DMA (master)
module beam_s2mm_framer #(
  parameter int unsigned DATA_W      = 128,
  parameter int unsigned FRAME_BEATS = 256,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      stop,
  output logic                      busy,
  output logic [31:0]               frame_count,
  beam_s2mm_framer_if.slave         s_axis_real,
  beam_s2mm_framer_if.slave         s_axis_imag,
  beam_s2mm_framer_if.master        m_axis_real_s2mm,
  beam_s2mm_framer_if.master        m_axis_imag_s2mm
);
  localparam int unsigned CW = $clog2(FRAME_BEATS);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] LAST_BEAT = CW'(FRAME_BEATS - 1);
  localparam logic [AW:0]   FULL_CNT  = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

  state_t            state, state_nx;
  logic [CW-1:0]     beat_cnt;
  logic              clear_cnt;
  logic              can_acc;
  logic              accept;
  logic              tlast_i;
  logic              at_boundary;
  logic [1:0]        full;
  logic [1:0]        empty;
  logic [1:0]        out_ready;
  logic [1:0]        head_last;
  logic [DATA_W-1:0] in_data   [2];
  logic [DATA_W-1:0] head_data [2];
  logic              unused_in;

  // Input-side tkeep/tlast carry no information for this stage.
  assign unused_in = ^{s_axis_real.tkeep, s_axis_real.tlast,
                       s_axis_imag.tkeep, s_axis_imag.tlast};

  assign in_data[0] = s_axis_real.tdata;
  assign in_data[1] = s_axis_imag.tdata;
  assign out_ready  = {m_axis_imag_s2mm.tready, m_axis_real_s2mm.tready};

  // Joint handshake: each lane's tready waits for the other lane's tvalid.
  assign can_acc            = (state != IDLE) && !full[0] && !full[1];
  assign s_axis_real.tready = can_acc && s_axis_imag.tvalid;
  assign s_axis_imag.tready = can_acc && s_axis_real.tvalid;
  assign accept             = can_acc && s_axis_real.tvalid && s_axis_imag.tvalid;
  assign tlast_i            = (beat_cnt == LAST_BEAT);

  // The frame boundary as seen after this cycle: a stop that lands on the
  // cycle a frame completes (or while no frame is open) closes capture at
  // once rather than opening another full frame.
  assign at_boundary = accept ? tlast_i : (beat_cnt == '0);

  always_comb begin
    state_nx  = state;
    clear_cnt = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nx  = RUN;
          clear_cnt = 1'b1;
        end
      end
      RUN: begin
        if (stop) state_nx = at_boundary ? IDLE : STOPPING;
      end
      STOPPING: begin
        if (accept && tlast_i) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      beat_cnt    <= '0;
      frame_count <= '0;
    end else begin
      state <= state_nx;
      if (clear_cnt)   beat_cnt <= '0;
      else if (accept) beat_cnt <= tlast_i ? '0 : beat_cnt + CW'(1);
      if (accept && tlast_i) frame_count <= frame_count + 32'd1;
    end
  end

  // Per-lane FIFO of {tlast, tdata}; pushes are gated by can_acc so no push
  // happens at full even if the same lane pops in that cycle.
  for (genvar l = 0; l < 2; l++) begin : g_lane
    logic [DATA_W:0] mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic            pop;

    assign pop          = (count != '0) && out_ready[l];
    assign full[l]      = (count == FULL_CNT);
    assign empty[l]     = (count == '0);
    assign head_data[l] = mem[rd_ptr][DATA_W-1:0];
    assign head_last[l] = mem[rd_ptr][DATA_W];

    always_ff @(posedge clock) begin
      if (reset) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (accept) begin
          mem[wr_ptr] <= {tlast_i, in_data[l]};
          wr_ptr      <= wr_ptr + AW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        case ({accept, pop})
          2'b10:   count <= count + (AW+1)'(1);
          2'b01:   count <= count - (AW+1)'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Outputs are forced to zero while a lane is empty so nothing stale leaks.
  assign m_axis_real_s2mm.tvalid = !empty[0];
  assign m_axis_real_s2mm.tdata  = empty[0] ? '0 : head_data[0];
  assign m_axis_real_s2mm.tlast  = !empty[0] && head_last[0];
  assign m_axis_real_s2mm.tkeep  = empty[0] ? '0 : '1;

  assign m_axis_imag_s2mm.tvalid = !empty[1];
  assign m_axis_imag_s2mm.tdata  = empty[1] ? '0 : head_data[1];
  assign m_axis_imag_s2mm.tlast  = !empty[1] && head_last[1];
  assign m_axis_imag_s2mm.tkeep  = empty[1] ? '0 : '1;

  assign busy = (state != IDLE) || !empty[0] || !empty[1];
endmodule

// File: tb/tb_beam_s2mm_framer.sv
module tb_beam_s2mm_framer;
  localparam int unsigned DW = 128;
  localparam int unsigned FB = 4;
  localparam int unsigned FD = 4;

  logic        clock = 1'b0;
  logic        reset, start, stop;
  logic        busy;
  logic [31:0] frame_count;

  beam_s2mm_framer_if #(.DATA_W(DW)) s_r ();
  beam_s2mm_framer_if #(.DATA_W(DW)) s_i ();
  beam_s2mm_framer_if #(.DATA_W(DW)) m_r ();
  beam_s2mm_framer_if #(.DATA_W(DW)) m_i ();

  beam_s2mm_framer #(.DATA_W(DW), .FRAME_BEATS(FB), .FIFO_DEPTH(FD)) dut (
    .clock            (clock),
    .reset            (reset),
    .start            (start),
    .stop             (stop),
    .busy             (busy),
    .frame_count      (frame_count),
    .s_axis_real      (s_r),
    .s_axis_imag      (s_i),
    .m_axis_real_s2mm (m_r),
    .m_axis_imag_s2mm (m_i)
  );

  always #5 clock = ~clock;

  int unsigned errors = 0;
  int unsigned checks = 0;

  // Reference model: expected output per lane is the accepted input sequence,
  // with tlast on every FB-th beat counted from the start of capture.
  logic [DW:0] exp_r[$], exp_i[$], got_r[$], got_i[$];
  int unsigned beat_idx;
  int unsigned exp_frames;
  time first_acc, first_pop_r, first_pop_i;

  always @(negedge clock) begin
    if (m_r.tvalid === 1'b1 && m_r.tready === 1'b1) begin
      if (got_r.size() == 0) first_pop_r = $time;
      got_r.push_back({m_r.tlast, m_r.tdata});
    end
    if (m_i.tvalid === 1'b1 && m_i.tready === 1'b1) begin
      if (got_i.size() == 0) first_pop_i = $time;
      got_i.push_back({m_i.tlast, m_i.tdata});
    end
  end

  task automatic set_idle();
    s_r.tvalid = 1'b0;
    s_i.tvalid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; stop = 1'b0;
    set_idle();
    s_r.tdata = '0; s_i.tdata = '0;
    m_r.tready = 1'b0; m_i.tready = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    exp_r.delete(); exp_i.delete(); got_r.delete(); got_i.delete();
    beat_idx = 0; exp_frames = 0;
  endtask

  task automatic pulse(input logic st, input logic sp);
    start = st; stop = sp;
    @(posedge clock); #1;
    start = 1'b0; stop = 1'b0;
  endtask

  task automatic drain();
    m_r.tready = 1'b1; m_i.tready = 1'b1;
    repeat (FD + 4) @(posedge clock);
    #1;
  endtask

  // Holds a beat on both lanes until the joint handshake is seen; tvalid is
  // left high so consecutive calls stream back to back.
  task automatic send_beat(input logic [DW-1:0] dr, input logic [DW-1:0] di, output bit ok);
    s_r.tdata = dr; s_i.tdata = di;
    s_r.tvalid = 1'b1; s_i.tvalid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clock);
      if (s_r.tready === 1'b1 && s_i.tready === 1'b1) begin
        ok = 1'b1;
        if (exp_r.size() == 0) first_acc = $time;
      end
      @(posedge clock); #1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL accept_timeout got=no_accept exp=accept data=%h", dr);
    end else begin
      exp_r.push_back({beat_idx == FB - 1, dr});
      exp_i.push_back({beat_idx == FB - 1, di});
      if (beat_idx == FB - 1) exp_frames++;
      beat_idx = (beat_idx + 1) % FB;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; stop = 1'b0;
    s_r.tvalid = 1'b1; s_i.tvalid = 1'b1;
    s_r.tdata = '1; s_i.tdata = '1;
    s_r.tkeep = '1; s_i.tkeep = '1; s_r.tlast = 1'b0; s_i.tlast = 1'b0;
    m_r.tready = 1'b1; m_i.tready = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++;
    if ({busy, m_r.tvalid, m_i.tvalid, m_r.tlast, m_i.tlast, s_r.tready, s_i.tready} !== 7'b0) begin
      errors++;
      $display("FAIL reset_flags got=%b exp=0000000",
               {busy, m_r.tvalid, m_i.tvalid, m_r.tlast, m_i.tlast, s_r.tready, s_i.tready});
    end
    checks++;
    if (frame_count !== 32'd0) begin
      errors++; $display("FAIL reset_frame_count got=%0d exp=0", frame_count);
    end
    checks++;
    if ({m_r.tdata, m_i.tdata} !== '0) begin
      errors++; $display("FAIL reset_tdata got=%h/%h exp=0", m_r.tdata, m_i.tdata);
    end
    checks++;
    if ({m_r.tkeep, m_i.tkeep} !== 32'h0) begin
      errors++; $display("FAIL reset_tkeep got=%h/%h exp=0", m_r.tkeep, m_i.tkeep);
    end
    @(posedge clock); #1;
    do_reset();
  endtask

  task automatic test_run_full();
    bit ok;
    time t0;
    do_reset();
    m_r.tready = 1'b1; m_i.tready = 1'b1;
    pulse(1'b1, 1'b0);
    t0 = $time;
    for (int k = 0; k < 12; k++) send_beat(DW'(k), DW'(k + 1000), ok);
    checks++;
    if ($time - t0 != 120) begin
      errors++; $display("FAIL run_throughput got=%0t exp=120 (12 cycles)", $time - t0);
    end
    set_idle();
    @(negedge clock);
    checks++;
    if (frame_count !== 32'd3) begin
      errors++; $display("FAIL run_frame_count got=%0d exp=3", frame_count);
    end
    checks++;
    if (m_r.tkeep !== 16'hFFFF || m_i.tkeep !== 16'hFFFF) begin
      errors++; $display("FAIL run_tkeep got=%h/%h exp=ffff", m_r.tkeep, m_i.tkeep);
    end
    @(posedge clock); #1;
    pulse(1'b0, 1'b1);
    drain();
    checks++;
    if (first_pop_r - first_acc != 10 || first_pop_i - first_acc != 10) begin
      errors++;
      $display("FAIL run_latency got=%0t/%0t exp=10", first_pop_r - first_acc, first_pop_i - first_acc);
    end
    @(negedge clock);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL run_busy_end got=%b exp=0", busy);
    end
    @(posedge clock); #1;
    checks++;
    if (got_r.size() != 12 || got_i.size() != 12) begin
      errors++; $display("FAIL run_count got=%0d/%0d exp=12", got_r.size(), got_i.size());
    end
    for (int k = 0; k < exp_r.size() && k < got_r.size() && k < got_i.size(); k++) begin
      checks++;
      if (got_r[k] !== exp_r[k] || got_i[k] !== exp_i[k]) begin
        errors++;
        $display("FAIL run_seq[%0d] got=%h/%h exp=%h/%h", k, got_r[k], got_i[k], exp_r[k], exp_i[k]);
      end
    end
  endtask

  task automatic test_lane_skew();
    bit ok;
    do_reset();
    m_r.tready = 1'b1; m_i.tready = 1'b1;
    pulse(1'b1, 1'b0);
    s_r.tdata = DW'(50); s_r.tvalid = 1'b1; s_i.tvalid = 1'b0;
    repeat (5) begin
      @(negedge clock);
      checks++;
      if (s_r.tready !== 1'b0) begin
        errors++; $display("FAIL skew_real_tready got=%b exp=0", s_r.tready);
      end
      @(posedge clock); #1;
    end
    checks++;
    if (got_r.size() != 0 || got_i.size() != 0) begin
      errors++; $display("FAIL skew_no_accept got=%0d/%0d exp=0", got_r.size(), got_i.size());
    end
    m_i.tready = 1'b0;
    for (int k = 0; k < 4; k++) send_beat(DW'(50 + k), DW'(90 + k), ok);
    s_r.tdata = DW'(54); s_i.tdata = DW'(94);
    repeat (6) begin
      @(negedge clock);
      checks++;
      if (s_r.tready !== 1'b0 || s_i.tready !== 1'b0) begin
        errors++; $display("FAIL skew_stall got=%b%b exp=00", s_r.tready, s_i.tready);
      end
      @(posedge clock); #1;
    end
    checks++;
    if (got_r.size() != 4 || got_i.size() != 0 || m_r.tvalid !== 1'b0 || m_i.tvalid !== 1'b1) begin
      errors++;
      $display("FAIL skew_drain got=r%0d i%0d vr%b vi%b exp=r4 i0 vr0 vi1",
               got_r.size(), got_i.size(), m_r.tvalid, m_i.tvalid);
    end
    m_i.tready = 1'b1;
    for (int k = 4; k < 8; k++) send_beat(DW'(50 + k), DW'(90 + k), ok);
    set_idle();
    pulse(1'b0, 1'b1);
    drain();
    checks++;
    if (frame_count !== 32'd2 || got_r.size() != 8 || got_i.size() != 8) begin
      errors++;
      $display("FAIL skew_totals got=fc%0d r%0d i%0d exp=fc2 r8 i8", frame_count, got_r.size(), got_i.size());
    end
    for (int k = 0; k < exp_r.size() && k < got_r.size() && k < got_i.size(); k++) begin
      checks++;
      if (got_r[k] !== exp_r[k] || got_i[k] !== exp_i[k]) begin
        errors++;
        $display("FAIL skew_seq[%0d] got=%h/%h exp=%h/%h", k, got_r[k], got_i[k], exp_r[k], exp_i[k]);
      end
    end
  endtask

  task automatic test_stop_mid();
    bit ok;
    do_reset();
    pulse(1'b1, 1'b0);
    for (int k = 0; k < 2; k++) send_beat(DW'(200 + k), DW'(300 + k), ok);
    set_idle();
    pulse(1'b0, 1'b1);
    for (int k = 2; k < 4; k++) send_beat(DW'(200 + k), DW'(300 + k), ok);
    @(negedge clock);
    checks++;
    if (s_r.tready !== 1'b0 || frame_count !== 32'd1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL stop_mid_state got=rdy%b fc%0d busy%b exp=rdy0 fc1 busy1", s_r.tready, frame_count, busy);
    end
    @(posedge clock); #1;
    m_r.tready = 1'b1; m_i.tready = 1'b1;
    repeat (4) begin
      @(negedge clock);
      checks++;
      if (s_r.tready !== 1'b0 || s_i.tready !== 1'b0) begin
        errors++; $display("FAIL stop_mid_idle_tready got=%b%b exp=00", s_r.tready, s_i.tready);
      end
      @(posedge clock); #1;
    end
    set_idle();
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clock);
      if (busy === 1'b0) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      errors++; $display("FAIL stop_mid_busy_fall got=%b exp=0", busy);
    end
    @(posedge clock); #1;
    checks++;
    if (got_r.size() != 4 || got_i.size() != 4) begin
      errors++; $display("FAIL stop_mid_count got=%0d/%0d exp=4", got_r.size(), got_i.size());
    end
    for (int k = 0; k < exp_r.size() && k < got_r.size() && k < got_i.size(); k++) begin
      checks++;
      if (got_r[k] !== exp_r[k] || got_i[k] !== exp_i[k]) begin
        errors++;
        $display("FAIL stop_mid_seq[%0d] got=%h/%h exp=%h/%h", k, got_r[k], got_i[k], exp_r[k], exp_i[k]);
      end
    end
  endtask

  task automatic test_stop_boundary();
    bit ok;
    time t0;
    do_reset();
    m_r.tready = 1'b1; m_i.tready = 1'b1;
    pulse(1'b1, 1'b0);
    for (int k = 0; k < 4; k++) send_beat(DW'(400 + k), DW'(500 + k), ok);
    set_idle();
    pulse(1'b0, 1'b1);
    s_r.tvalid = 1'b1; s_i.tvalid = 1'b1;
    repeat (3) begin
      @(negedge clock);
      checks++;
      if (s_r.tready !== 1'b0 || s_i.tready !== 1'b0) begin
        errors++; $display("FAIL boundary_idle_tready got=%b%b exp=00", s_r.tready, s_i.tready);
      end
      @(posedge clock); #1;
    end
    set_idle();
    checks++;
    if (frame_count !== 32'd1) begin
      errors++; $display("FAIL boundary_frame_count got=%0d exp=1", frame_count);
    end
    pulse(1'b1, 1'b1);
    t0 = $time;
    send_beat(DW'(404), DW'(504), ok);
    checks++;
    if ($time - t0 != 10) begin
      errors++; $display("FAIL idle_start_stop_run got=%0t exp=10", $time - t0);
    end
    set_idle();
    pulse(1'b1, 1'b1);
    for (int k = 5; k < 8; k++) send_beat(DW'(400 + k), DW'(500 + k), ok);
    @(negedge clock);
    checks++;
    if (s_r.tready !== 1'b0 || frame_count !== 32'd2) begin
      errors++;
      $display("FAIL run_start_stop_end got=rdy%b fc%0d exp=rdy0 fc2", s_r.tready, frame_count);
    end
    @(posedge clock); #1;
    set_idle();
    drain();
    checks++;
    if (got_r.size() != 8 || got_i.size() != 8) begin
      errors++; $display("FAIL boundary_count got=%0d/%0d exp=8", got_r.size(), got_i.size());
    end
    for (int k = 0; k < exp_r.size() && k < got_r.size() && k < got_i.size(); k++) begin
      checks++;
      if (got_r[k] !== exp_r[k] || got_i[k] !== exp_i[k]) begin
        errors++;
        $display("FAIL boundary_seq[%0d] got=%h/%h exp=%h/%h", k, got_r[k], got_i[k], exp_r[k], exp_i[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    m_r.tready = 1'b1; m_i.tready = 1'b1;
    pulse(1'b1, 1'b0);
    for (int k = 0; k < 4; k++) send_beat(DW'(600 + k), DW'(700 + k), ok);
    m_r.tready = 1'b0; m_i.tready = 1'b0;
    for (int k = 4; k < 6; k++) send_beat(DW'(600 + k), DW'(700 + k), ok);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if ({m_r.tvalid, m_i.tvalid, m_r.tlast, m_i.tlast, busy, s_r.tready, s_i.tready} !== 7'b0) begin
      errors++;
      $display("FAIL reset_mid_flags got=%b exp=0000000",
               {m_r.tvalid, m_i.tvalid, m_r.tlast, m_i.tlast, busy, s_r.tready, s_i.tready});
    end
    checks++;
    if (frame_count !== 32'd0 || {m_r.tdata, m_i.tdata} !== '0) begin
      errors++;
      $display("FAIL reset_mid_data got=fc%0d d%h/%h exp=0", frame_count, m_r.tdata, m_i.tdata);
    end
    @(posedge clock); #1;
    set_idle();
    exp_r.delete(); exp_i.delete(); got_r.delete(); got_i.delete();
    beat_idx = 0; exp_frames = 0;
    m_r.tready = 1'b1; m_i.tready = 1'b1;
    pulse(1'b1, 1'b0);
    for (int k = 0; k < 4; k++) send_beat(DW'(800 + k), DW'(900 + k), ok);
    set_idle();
    pulse(1'b0, 1'b1);
    drain();
    checks++;
    if (frame_count !== 32'd1 || got_r.size() != 4 || got_i.size() != 4) begin
      errors++;
      $display("FAIL reset_mid_restart got=fc%0d r%0d i%0d exp=fc1 r4 i4", frame_count, got_r.size(), got_i.size());
    end
    for (int k = 0; k < exp_r.size() && k < got_r.size() && k < got_i.size(); k++) begin
      checks++;
      if (got_r[k] !== exp_r[k] || got_i[k] !== exp_i[k]) begin
        errors++;
        $display("FAIL reset_mid_seq[%0d] got=%h/%h exp=%h/%h", k, got_r[k], got_i[k], exp_r[k], exp_i[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    bit done;
    int unsigned guard;
    logic [DW-1:0] dr, di;
    logic ph_r, ph_i;
    logic [DW:0] pd_r, pd_i;
    do_reset();
    pulse(1'b1, 1'b0);
    done = 1'b0; ok = 1'b1; guard = 0;
    ph_r = 1'b0; ph_i = 1'b0; pd_r = '0; pd_i = '0;
    fork
      begin
        for (int k = 0; k < 1000 && ok; k++) begin
          if ($urandom_range(3) == 0) begin
            set_idle();
            @(posedge clock); #1;
          end
          dr = {$urandom(), $urandom(), $urandom(), $urandom()};
          di = {$urandom(), $urandom(), $urandom(), $urandom()};
          send_beat(dr, di, ok);
        end
        set_idle();
        done = 1'b1;
      end
      begin
        while (!done && guard < 30000) begin
          m_r.tready = 1'($urandom_range(1));
          m_i.tready = 1'($urandom_range(1));
          @(negedge clock);
          if (ph_r) begin
            checks++;
            if ({m_r.tvalid, m_r.tlast, m_r.tdata} !== {1'b1, pd_r}) begin
              errors++; $display("FAIL hold_real got=%b%h exp=1%h", m_r.tvalid, {m_r.tlast, m_r.tdata}, pd_r);
            end
          end
          if (ph_i) begin
            checks++;
            if ({m_i.tvalid, m_i.tlast, m_i.tdata} !== {1'b1, pd_i}) begin
              errors++; $display("FAIL hold_imag got=%b%h exp=1%h", m_i.tvalid, {m_i.tlast, m_i.tdata}, pd_i);
            end
          end
          ph_r = (m_r.tvalid === 1'b1) && (m_r.tready === 1'b0);
          ph_i = (m_i.tvalid === 1'b1) && (m_i.tready === 1'b0);
          pd_r = {m_r.tlast, m_r.tdata};
          pd_i = {m_i.tlast, m_i.tdata};
          @(posedge clock); #1;
          guard++;
        end
      end
    join
    checks++;
    if (!done) begin
      errors++; $display("FAIL bp_timeout got=unfinished exp=1000_beats");
    end
    pulse(1'b0, 1'b1);
    drain();
    checks++;
    if (frame_count !== 32'd250 || got_r.size() != 1000 || got_i.size() != 1000) begin
      errors++;
      $display("FAIL bp_totals got=fc%0d r%0d i%0d exp=fc250 r1000 i1000", frame_count, got_r.size(), got_i.size());
    end
    for (int k = 0; k < exp_r.size() && k < got_r.size() && k < got_i.size(); k++) begin
      checks++;
      if (got_r[k] !== exp_r[k] || got_i[k] !== exp_i[k]) begin
        errors++;
        $display("FAIL bp_seq[%0d] got=%h/%h exp=%h/%h", k, got_r[k], got_i[k], exp_r[k], exp_i[k]);
      end
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_run_full();
    test_lane_skew();
    test_stop_mid();
    test_stop_boundary();
    test_reset_mid();
    test_backpressure();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/beam_s2mm_framer.md
# beam_s2mm_framer

Output framing stage placed directly downstream of the four-channel beamforming adder. It takes the adder's combined beam as two lock-stepped AXI4-Stream lanes, one real and one imaginary, each carrying 8 × 16-bit samples per beat. It buffers each lane independently and cuts the stream into fixed-length frames marked with tlast, feeding two S2MM DMA channels. A start/stop control FSM gates capture so that frames are always whole.

## Interface
Parameters:
- DATA_W, 128, tdata width per lane (8 × 16-bit samples).
- FRAME_BEATS, 256, beats per frame; must be ≥ 2.
- FIFO_DEPTH, 4, entries per lane FIFO; power of 2, ≥ 2.

Ports:
- clock  in  1  single clock domain; all logic is rising-edge.
- reset  in  1  synchronous, active-high.
- start  in  1  single-cycle pulse; arms capture.
- stop  in  1  single-cycle pulse; requests stop at the next frame boundary.
- busy  out  1  high when state ≠ IDLE or either FIFO is non-empty.
- frame_count  out  32  number of complete frames accepted since reset; wraps.
- s_axis_real_tdata  in  DATA_W  beam real samples from the adder.
- s_axis_real_tvalid  in  1
- s_axis_real_tready  out  1
- s_axis_imag_tdata  in  DATA_W  beam imaginary samples from the adder.
- s_axis_imag_tvalid  in  1
- s_axis_imag_tready  out  1
- m_axis_real_s2mm_tdata  out  DATA_W
- m_axis_real_s2mm_tkeep  out  DATA_W/8  always all-ones while tvalid is high.
- m_axis_real_s2mm_tlast  out  1
- m_axis_real_s2mm_tvalid  out  1
- m_axis_real_s2mm_tready  in  1
- m_axis_imag_s2mm_tdata, m_axis_imag_s2mm_tkeep, m_axis_imag_s2mm_tlast, m_axis_imag_s2mm_tvalid (out), m_axis_imag_s2mm_tready (in): same as the real lane.

## Operation
- FSM states are IDLE, RUN and STOPPING.
  - IDLE: on start, go to RUN and clear beat_cnt. stop is ignored in IDLE.
  - RUN: on stop, go to STOPPING. Simultaneous start+stop also goes to STOPPING. start alone is ignored.
  - STOPPING: go to IDLE on the cycle the last beat of the frame (beat_cnt = FRAME_BEATS−1) is accepted. If beat_cnt = 0 when stop arrives in RUN, go directly to IDLE, so no partial frame is started.
- Input handshake is joint:
  - can_acc = (state ≠ IDLE) && real FIFO not full && imag FIFO not full.
  - s_axis_real_tready = can_acc && s_axis_imag_tvalid.
  - s_axis_imag_tready = can_acc && s_axis_real_tvalid.
  - A beat is accepted only when both lanes transfer in the same cycle. The lanes never slip relative to each other.
- On accept:
  - Each lane FIFO pushes {tdata, tlast_i}, where tlast_i = (beat_cnt == FRAME_BEATS−1).
  - beat_cnt increments and wraps to 0 after FRAME_BEATS−1.
  - frame_count increments when tlast_i = 1.
- A FIFO reports full at count = FIFO_DEPTH. There is no push at full, even when a pop occurs in the same cycle.
- Output lanes drain independently. Each lane pops on its own tvalid && tready. One lane may lead the other by up to FIFO_DEPTH beats.
- tdata passes through unmodified; there is no arithmetic or width change.
- tvalid = FIFO non-empty. tdata and tlast come from the FIFO head and stay stable while tvalid && !tready.

## Timing
- Reset values:
  - state = IDLE; both FIFOs empty; beat_cnt = 0; frame_count = 0.
  - All tvalid, tready, tlast and tdata outputs = 0; tkeep = 0; busy = 0.
- Reset mid-frame discards FIFO contents and any partial frame. The next capture starts a fresh frame.
- Latency: a beat accepted in cycle N is presented on the m_ tvalid outputs in cycle N+1 when its FIFO was empty.
- Throughput: 1 beat/cycle sustained while both m_ treadys stay high.
- start in cycle N: s_ tready can be high from cycle N+1.
- Reaching IDLE drops s_ tready the following cycle. FIFOs keep draining after the stop, and busy falls once both are empty.
- Boundaries:
  - beat_cnt wraps to 0 after the tlast beat.
  - frame_count wraps from 0xFFFF_FFFF to 0.
  - If one m_ tready is held low, its FIFO fills and input stalls. The other lane continues until it is empty.

## Test plan
- Run, full throughput: FRAME_BEATS = 4, start, both inputs valid with tdata incrementing 0,1,2…, both m_ treadys high → output beats appear one cycle after acceptance; tlast on beats 3, 7, 11…; frame_count = 3 after 12 beats; tkeep = 16'hFFFF.
- Lane skew: imag tvalid held low for 5 cycles while real is valid → no beats accepted and both s_ treadys are low. Then m_imag tready held low → the imag FIFO reaches 4 entries, input stalls, and the real lane drains to empty. Releasing m_imag tready delivers the beats in order with no loss.
- Stop mid-frame: stop pulse at beat 1 of a 4-beat frame → beats 2 and 3 are accepted; tready drops after beat 3; frame_count advances by 1; busy falls once both FIFOs are empty.
- Stop at a frame boundary: stop with beat_cnt = 0 → IDLE next cycle; no further beats are accepted. Simultaneous start+stop in RUN → STOPPING.
- Reset mid-frame: synchronous reset after 2 beats of a frame → all outputs and frame_count are 0 next cycle. Restarting gives tlast on the 4th beat after the new start.
- Backpressure stability: random m_ tready toggling over 1000 beats → tdata and tlast are held stable while tvalid && !tready, and both lanes' output sequences equal the input sequence.
